// File: rtl/medidor_pkg.sv
// Shared types and constants for the frequency meter.
// Holds the FSM state enumeration and the default counter width.
package medidor_pkg;

    localparam int LARGURA_PADRAO = 16;

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA_BORDA,
        MEDINDO
    } estado_t;

endpackage

// File: rtl/medidor_de_frequencia_if.sv
// Control/result bundle of the frequency meter.
// master: consumer (drives habilita/aceito); slave: meter (drives results).
interface medidor_de_frequencia_if
    import medidor_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) ();

    logic               habilita;
    logic               aceito;
    logic [LARGURA-1:0] periodo;
    logic               valido;
    logic               estouro;
    logic               perdido;

    modport master (
        output habilita, aceito,
        input  periodo, valido, estouro, perdido
    );

    modport slave (
        input  habilita, aceito,
        output periodo, valido, estouro, perdido
    );

endinterface

// File: rtl/sincronizador_2ff.sv
// Generic 1-bit two-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module sincronizador_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/medidor_de_frequencia.sv
// Period meter: counts clockPlaca cycles between rising edges of sinalEntrada.
// Ports: clockPlaca/resetPlaca, sinalEntrada, habilita, aceito -> periodo, valido, estouro, perdido.
module medidor_de_frequencia
    import medidor_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clockPlaca,
    input  logic               resetPlaca,
    input  logic               sinalEntrada,
    input  logic               habilita,
    input  logic               aceito,
    output logic [LARGURA-1:0] periodo,
    output logic               valido,
    output logic               estouro,
    output logic               perdido
);

    localparam logic [LARGURA-1:0] CONT_MAX = '1;

    logic               sinal_sync;
    logic               sinal_ant_q;
    logic               borda;
    logic               novo;
    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] contador_q, contador_d;
    logic [LARGURA-1:0] periodo_q, periodo_d;
    logic               valido_q, valido_d;
    logic               estouro_q, estouro_d;
    logic               perdido_q, perdido_d;

    sincronizador_2ff u_sinc (
        .clk   (clockPlaca),
        .rst_n (resetPlaca),
        .d     (sinalEntrada),
        .q     (sinal_sync)
    );

    // Third flop: edge detect against the previous synchronized sample.
    assign borda = sinal_sync & ~sinal_ant_q;

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        periodo_d  = periodo_q;
        estouro_d  = 1'b0;
        novo       = 1'b0;
        if (!habilita) begin
            estado_d   = OCIOSO;
            contador_d = '0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    estado_d = ESPERA_BORDA;
                end
                ESPERA_BORDA: begin
                    if (borda) begin
                        contador_d = LARGURA'(1);
                        estado_d   = MEDINDO;
                    end
                end
                MEDINDO: begin
                    if (borda) begin
                        novo       = 1'b1;
                        periodo_d  = contador_q;
                        contador_d = LARGURA'(1);
                    end else if (contador_q == CONT_MAX) begin
                        // No edge within range: drop the measurement and re-arm.
                        estouro_d  = 1'b1;
                        contador_d = '0;
                        estado_d   = ESPERA_BORDA;
                    end else begin
                        contador_d = contador_q + 1'b1;
                    end
                end
                default: begin
                    estado_d   = OCIOSO;
                    contador_d = '0;
                end
            endcase
        end
        // A result loaded in the same cycle as aceito replaces the accepted one.
        valido_d  = novo | (valido_q & ~aceito);
        perdido_d = novo & valido_q & ~aceito;
    end

    always_ff @(posedge clockPlaca or negedge resetPlaca) begin
        if (!resetPlaca) begin
            sinal_ant_q <= 1'b0;
            estado_q    <= OCIOSO;
            contador_q  <= '0;
            periodo_q   <= '0;
            valido_q    <= 1'b0;
            estouro_q   <= 1'b0;
            perdido_q   <= 1'b0;
        end else begin
            sinal_ant_q <= sinal_sync;
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            periodo_q   <= periodo_d;
            valido_q    <= valido_d;
            estouro_q   <= estouro_d;
            perdido_q   <= perdido_d;
        end
    end

    assign periodo = periodo_q;
    assign valido  = valido_q;
    assign estouro = estouro_q;
    assign perdido = perdido_q;

endmodule
